sha_msg_packer: RTL and testbench

//  Sits between scanner_control and the SHA-256 core. Accepts the 32-bit scanned barcode
//  and its HASH_START pulse, then builds the single padded 512-bit SHA-256 message block.

---
 rtl/sha_msg_packer_pkg.sv | 19 +
 rtl/sha_msg_packer_pad_word.sv | 27 ++
 rtl/sha_msg_packer.sv | 139 +++++++++++++
 tb/tb_sha_msg_packer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha_msg_packer_pkg.sv
// Shared definitions for the SHA-256 message packer: padding constants,
// block geometry and the packer FSM state encoding.
package sha_msg_packer_pkg;

  localparam logic [31:0] SHA_PAD_WORD    = 32'h8000_0000;
  localparam int unsigned SHA_BLOCK_WORDS = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    STREAM    = 2'd1,
    WAIT_DONE = 2'd2
  } state_e;

  // Final block word carries the message length in bits.
  function automatic logic [31:0] sha_len_word(input int unsigned bits);
    return 32'(bits);
  endfunction

endpackage

// File: rtl/sha_msg_packer_pad_word.sv
// sha_pad_word: combinational generator of word k of the single padded
// SHA-256 block for a 32-bit message.
//   idx     in  4   word index 0..15
//   barcode in  32  latched 32-bit message
//   word    out 32  block word W[idx]
module sha_pad_word
  import sha_msg_packer_pkg::*;
(
  input  logic [3:0]  idx,
  input  logic [31:0] barcode,
  output logic [31:0] word
);

  localparam logic [3:0] LAST_IDX = 4'(SHA_BLOCK_WORDS - 1);

  always_comb begin
    word = '0;
    if (idx == 4'd0) begin
      word = barcode;
    end else if (idx == 4'd1) begin
      word = SHA_PAD_WORD;
    end else if (idx == LAST_IDX) begin
      word = sha_len_word(32);
    end
  end

endmodule

// File: rtl/sha_msg_packer.sv
// sha_msg_packer: accepts a scanned barcode plus start pulse, streams the
// padded 512-bit SHA-256 block as 16 x 32-bit words over valid/ready, then
// waits for the core's done pulse (or a timeout) before becoming ready again.
//   CLOCK_50    in   clock
//   RESET       in   synchronous active-low reset
//   BARCODE     in   barcode word, HASH_START in start pulse
//   READY       out  idle / start accepted
//   WORD_OUT/WORD_INDEX/WORD_VALID/WORD_LAST out, WORD_READY in: word stream
//   HASH_DONE   in   core finished
//   DIGEST_DONE out  success pulse; DROPPED/TIMEOUT out sticky status
module sha_msg_packer
  import sha_msg_packer_pkg::*;
#(
  parameter int unsigned DEDUP          = 1,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned TO_W           = 20
) (
  input  logic        CLOCK_50,
  input  logic        RESET,
  input  logic [31:0] BARCODE,
  input  logic        HASH_START,
  output logic        READY,
  output logic [31:0] WORD_OUT,
  output logic [3:0]  WORD_INDEX,
  output logic        WORD_VALID,
  output logic        WORD_LAST,
  input  logic        WORD_READY,
  input  logic        HASH_DONE,
  output logic        DIGEST_DONE,
  output logic        DROPPED,
  output logic        TIMEOUT
);

  localparam logic [3:0]      LAST_IDX = 4'(SHA_BLOCK_WORDS - 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  state_e          state_q, state_d;
  logic [3:0]      idx_q, idx_d;
  // The latched barcode doubles as the last-accepted register for dedup.
  logic [31:0]     barcode_q, barcode_d;
  logic            last_valid_q, last_valid_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            digest_done_q, digest_done_d;
  logic            dropped_q, dropped_d;
  logic            timeout_q, timeout_d;
  logic            start_dup;
  logic [31:0]     pad_word;

  sha_pad_word u_pad (
    .idx     (idx_q),
    .barcode (barcode_q),
    .word    (pad_word)
  );

  assign start_dup = (DEDUP != 0) && last_valid_q && (BARCODE == barcode_q);

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    barcode_d     = barcode_q;
    last_valid_d  = last_valid_q;
    to_cnt_d      = to_cnt_q;
    digest_done_d = 1'b0;
    dropped_d     = dropped_q;
    timeout_d     = timeout_q;
    unique case (state_q)
      IDLE: begin
        if (HASH_START) begin
          if (start_dup) begin
            dropped_d = 1'b1;
          end else begin
            barcode_d    = BARCODE;
            last_valid_d = 1'b1;
            idx_d        = '0;
            state_d      = STREAM;
          end
        end
      end
      STREAM: begin
        if (HASH_START) dropped_d = 1'b1;
        if (WORD_READY) begin
          if (idx_q == LAST_IDX) begin
            idx_d    = '0;
            to_cnt_d = '0;
            state_d  = WAIT_DONE;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      WAIT_DONE: begin
        if (HASH_START) dropped_d = 1'b1;
        // Done on the terminal-count cycle takes priority over timeout.
        if (HASH_DONE) begin
          digest_done_d = 1'b1;
          state_d       = IDLE;
        end else if (to_cnt_q == TO_LAST) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      barcode_q     <= '0;
      last_valid_q  <= 1'b0;
      to_cnt_q      <= '0;
      digest_done_q <= 1'b0;
      dropped_q     <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      barcode_q     <= barcode_d;
      last_valid_q  <= last_valid_d;
      to_cnt_q      <= to_cnt_d;
      digest_done_q <= digest_done_d;
      dropped_q     <= dropped_d;
      timeout_q     <= timeout_d;
    end
  end

  assign READY       = (state_q == IDLE);
  assign WORD_VALID  = (state_q == STREAM);
  assign WORD_LAST   = (state_q == STREAM) && (idx_q == LAST_IDX);
  assign WORD_INDEX  = idx_q;
  assign WORD_OUT    = (state_q == STREAM) ? pad_word : '0;
  assign DIGEST_DONE = digest_done_q;
  assign DROPPED     = dropped_q;
  assign TIMEOUT     = timeout_q;

endmodule

// File: tb/tb_sha_msg_packer.sv
// Directed bench for sha_msg_packer (DEDUP=1, TIMEOUT_CYCLES=8).
module tb_sha_msg_packer;

  logic        clk = 1'b0;
  logic        RESET, HASH_START, WORD_READY, HASH_DONE;
  logic [31:0] BARCODE;
  logic        READY, WORD_VALID, WORD_LAST, DIGEST_DONE, DROPPED, TIMEOUT;
  logic [31:0] WORD_OUT;
  logic [3:0]  WORD_INDEX;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sha_msg_packer #(.DEDUP(1), .TIMEOUT_CYCLES(8), .TO_W(4)) dut (
    .CLOCK_50(clk), .RESET(RESET), .BARCODE(BARCODE), .HASH_START(HASH_START),
    .READY(READY), .WORD_OUT(WORD_OUT), .WORD_INDEX(WORD_INDEX),
    .WORD_VALID(WORD_VALID), .WORD_LAST(WORD_LAST), .WORD_READY(WORD_READY),
    .HASH_DONE(HASH_DONE), .DIGEST_DONE(DIGEST_DONE), .DROPPED(DROPPED),
    .TIMEOUT(TIMEOUT)
  );

  function automatic logic [31:0] exp_word(input int k, input logic [31:0] bc);
    if (k == 0)  return bc;
    if (k == 1)  return 32'h8000_0000;
    if (k == 15) return 32'h0000_0020;
    return 32'h0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b0; HASH_START = 1'b0; HASH_DONE = 1'b0; WORD_READY = 1'b0;
    tick();
    RESET = 1'b1;
  endtask

  task automatic start(input logic [31:0] bc);
    BARCODE = bc; HASH_START = 1'b1;
    tick();
    HASH_START = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b0; BARCODE = '0; HASH_START = 1'b0; WORD_READY = 1'b0; HASH_DONE = 1'b0;
    tick();
    checks++;
    if ({READY, WORD_VALID, WORD_LAST, DIGEST_DONE, DROPPED, TIMEOUT} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 100000",
               {READY, WORD_VALID, WORD_LAST, DIGEST_DONE, DROPPED, TIMEOUT});
    end
    checks++;
    if (WORD_INDEX !== 4'd0) begin errors++; $display("FAIL reset_index: got %0d expected 0", WORD_INDEX); end
    checks++;
    if (WORD_OUT !== 32'h0) begin errors++; $display("FAIL reset_word: got %h expected 0", WORD_OUT); end
    RESET = 1'b1;
  endtask

  task automatic test_stream();
    WORD_READY = 1'b1;
    start(32'h1234_ABCD);
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (WORD_VALID !== 1'b1 || WORD_INDEX !== 4'(k)) begin
        errors++; $display("FAIL stream_idx: got v=%b idx=%0d expected v=1 idx=%0d", WORD_VALID, WORD_INDEX, k);
      end
      checks++;
      if (WORD_OUT !== exp_word(k, 32'h1234_ABCD)) begin
        errors++; $display("FAIL stream_word%0d: got %h expected %h", k, WORD_OUT, exp_word(k, 32'h1234_ABCD));
      end
      checks++;
      if (WORD_LAST !== (k == 15) || READY !== 1'b0 || DIGEST_DONE !== 1'b0) begin
        errors++; $display("FAIL stream_ctl%0d: got last=%b ready=%b done=%b expected last=%b ready=0 done=0",
                           k, WORD_LAST, READY, DIGEST_DONE, (k == 15));
      end
      // A stray HASH_DONE mid-stream must be ignored.
      HASH_DONE = (k == 3);
      tick();
    end
    HASH_DONE = 1'b0;
    checks++;
    if (WORD_VALID !== 1'b0 || WORD_LAST !== 1'b0 || READY !== 1'b0) begin
      errors++; $display("FAIL stream_after: got v=%b last=%b ready=%b expected 0 0 0", WORD_VALID, WORD_LAST, READY);
    end
    tick();
    HASH_DONE = 1'b1;
    tick();
    HASH_DONE = 1'b0;
    checks++;
    if (DIGEST_DONE !== 1'b1 || READY !== 1'b1) begin
      errors++; $display("FAIL stream_done: got done=%b ready=%b expected 1 1", DIGEST_DONE, READY);
    end
    tick();
    checks++;
    if (DIGEST_DONE !== 1'b0 || READY !== 1'b1) begin
      errors++; $display("FAIL stream_done_pulse: got done=%b ready=%b expected 0 1", DIGEST_DONE, READY);
    end
  endtask

  task automatic test_stall();
    int k;
    do_reset();
    start(32'h1234_ABCD);
    k = 0;
    for (int cyc = 0; cyc < 64 && k < 16; cyc++) begin
      WORD_READY = cyc[0];
      checks++;
      if (WORD_VALID !== 1'b1 || WORD_INDEX !== 4'(k) || WORD_OUT !== exp_word(k, 32'h1234_ABCD)) begin
        errors++; $display("FAIL stall_word: cyc %0d got v=%b idx=%0d w=%h expected v=1 idx=%0d w=%h",
                           cyc, WORD_VALID, WORD_INDEX, WORD_OUT, k, exp_word(k, 32'h1234_ABCD));
      end
      tick();
      if (WORD_READY) k++;
    end
    checks++;
    if (k != 16 || WORD_VALID !== 1'b0) begin
      errors++; $display("FAIL stall_count: got %0d words v=%b expected 16 words v=0", k, WORD_VALID);
    end
    HASH_DONE = 1'b1;
    tick();
    HASH_DONE = 1'b0;
    checks++;
    if (DIGEST_DONE !== 1'b1) begin errors++; $display("FAIL stall_done: got %b expected 1", DIGEST_DONE); end
  endtask

  task automatic test_drop_busy();
    do_reset();
    WORD_READY = 1'b1;
    start(32'h1234_ABCD);
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (WORD_INDEX !== 4'(k) || WORD_OUT !== exp_word(k, 32'h1234_ABCD)) begin
        errors++; $display("FAIL busy_word: got idx=%0d w=%h expected idx=%0d w=%h",
                           WORD_INDEX, WORD_OUT, k, exp_word(k, 32'h1234_ABCD));
      end
      checks++;
      if (DROPPED !== (k >= 8)) begin
        errors++; $display("FAIL busy_dropped%0d: got %b expected %b", k, DROPPED, (k >= 8));
      end
      if (k == 7) begin BARCODE = 32'hDEAD_BEEF; HASH_START = 1'b1; end
      else HASH_START = 1'b0;
      tick();
    end
    HASH_START = 1'b0;
    HASH_DONE = 1'b1;
    tick();
    HASH_DONE = 1'b0;
    checks++;
    if (DIGEST_DONE !== 1'b1 || DROPPED !== 1'b1) begin
      errors++; $display("FAIL busy_end: got done=%b dropped=%b expected 1 1", DIGEST_DONE, DROPPED);
    end
  endtask

  task automatic test_dedup();
    do_reset();
    WORD_READY = 1'b1;
    start(32'h1234_ABCD);
    repeat (16) tick();
    HASH_DONE = 1'b1;
    tick();
    HASH_DONE = 1'b0;
    checks++;
    if (READY !== 1'b1 || DIGEST_DONE !== 1'b1 || DROPPED !== 1'b0) begin
      errors++; $display("FAIL dedup_first: got ready=%b done=%b dropped=%b expected 1 1 0", READY, DIGEST_DONE, DROPPED);
    end
    start(32'h1234_ABCD);
    checks++;
    if (WORD_VALID !== 1'b0 || READY !== 1'b1 || DROPPED !== 1'b1) begin
      errors++; $display("FAIL dedup_repeat: got v=%b ready=%b dropped=%b expected 0 1 1", WORD_VALID, READY, DROPPED);
    end
    start(32'h0000_0042);
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (WORD_VALID !== 1'b1 || WORD_INDEX !== 4'(k) || WORD_OUT !== exp_word(k, 32'h0000_0042)) begin
        errors++; $display("FAIL dedup_new: got v=%b idx=%0d w=%h expected v=1 idx=%0d w=%h",
                           WORD_VALID, WORD_INDEX, WORD_OUT, k, exp_word(k, 32'h0000_0042));
      end
      tick();
    end
    HASH_DONE = 1'b1;
    tick();
    HASH_DONE = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    WORD_READY = 1'b1;
    // Done arriving on the terminal-count cycle beats the timeout.
    start(32'hA5A5_0001);
    repeat (16) tick();
    for (int i = 1; i < 8; i++) begin
      tick();
      checks++;
      if (READY !== 1'b0 || TIMEOUT !== 1'b0) begin
        errors++; $display("FAIL to_race_wait%0d: got ready=%b to=%b expected 0 0", i, READY, TIMEOUT);
      end
    end
    HASH_DONE = 1'b1;
    tick();
    HASH_DONE = 1'b0;
    checks++;
    if (DIGEST_DONE !== 1'b1 || TIMEOUT !== 1'b0 || READY !== 1'b1) begin
      errors++; $display("FAIL to_race: got done=%b to=%b ready=%b expected 1 0 1", DIGEST_DONE, TIMEOUT, READY);
    end
    start(32'h5A5A_0002);
    repeat (16) tick();
    for (int i = 1; i < 8; i++) begin
      tick();
      checks++;
      if (READY !== 1'b0 || TIMEOUT !== 1'b0 || DIGEST_DONE !== 1'b0) begin
        errors++; $display("FAIL to_wait%0d: got ready=%b to=%b done=%b expected 0 0 0", i, READY, TIMEOUT, DIGEST_DONE);
      end
    end
    tick();
    checks++;
    if (TIMEOUT !== 1'b1 || READY !== 1'b1 || DIGEST_DONE !== 1'b0) begin
      errors++; $display("FAIL to_fire: got to=%b ready=%b done=%b expected 1 1 0", TIMEOUT, READY, DIGEST_DONE);
    end
    tick();
    checks++;
    if (TIMEOUT !== 1'b1 || DIGEST_DONE !== 1'b0) begin
      errors++; $display("FAIL to_sticky: got to=%b done=%b expected 1 0", TIMEOUT, DIGEST_DONE);
    end
  endtask

  task automatic test_reset_mid();
    // TIMEOUT is still set from the previous test; reset here must clear it.
    WORD_READY = 1'b1;
    start(32'hCAFE_F00D);
    repeat (3) tick();
    BARCODE = 32'h1111_1111; HASH_START = 1'b1;
    tick();
    HASH_START = 1'b0;
    tick();
    tick();
    checks++;
    if (DROPPED !== 1'b1 || WORD_INDEX !== 4'd6) begin
      errors++; $display("FAIL rmid_pre: got dropped=%b idx=%0d expected 1 6", DROPPED, WORD_INDEX);
    end
    RESET = 1'b0;
    tick();
    RESET = 1'b1;
    checks++;
    if ({WORD_VALID, WORD_LAST, READY, DROPPED, TIMEOUT, DIGEST_DONE} !== 6'b001000) begin
      errors++; $display("FAIL rmid_flags: got %b expected 001000",
                         {WORD_VALID, WORD_LAST, READY, DROPPED, TIMEOUT, DIGEST_DONE});
    end
    checks++;
    if (WORD_INDEX !== 4'd0 || WORD_OUT !== 32'h0) begin
      errors++; $display("FAIL rmid_word: got idx=%0d w=%h expected 0 0", WORD_INDEX, WORD_OUT);
    end
    tick();
    checks++;
    if (WORD_VALID !== 1'b0) begin errors++; $display("FAIL rmid_quiet: got v=%b expected 0", WORD_VALID); end
    start(32'hCAFE_F00D);
    checks++;
    if (WORD_VALID !== 1'b1 || WORD_INDEX !== 4'd0 || WORD_OUT !== 32'hCAFE_F00D || DROPPED !== 1'b0) begin
      errors++; $display("FAIL rmid_restart: got v=%b idx=%0d w=%h dropped=%b expected 1 0 cafef00d 0",
                         WORD_VALID, WORD_INDEX, WORD_OUT, DROPPED);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_drop_busy();
    test_dedup();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
